// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: synchronous FIFO with occupancy level, threshold flags and sticky error flags
//   clk, rst            : rising-edge clock, synchronous active-low reset
//   wr, din             : write request and data
//   rd, dout            : read request and data
//   full, empty         : level == DEPTH / level == 0
//   almost_full/_empty  : level >= AF_THRESH / level <= AE_THRESH
//   level               : occupancy 0..DEPTH
//   overflow, underflow : sticky rejected-write / rejected-read flags, cleared by clr_err
//   FIFO_FWFT_EN        : when defined, dout presents the head word combinationally (first-word-fall-through)
module sync_fifo_lvl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int AF_THRESH = (1 << ADDR_W) - 2,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_L = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_L = (ADDR_W+1)'(AE_THRESH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_ok, rd_ok;
  assign full         = level_q == DEPTH_L;
  assign empty        = level_q == '0;
  assign almost_full  = level_q >= AF_L;
  assign almost_empty = level_q <= AE_L;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign rd_ok = rd & ~empty;
  // a full FIFO still takes a write when a read frees the head slot on the same edge
  assign wr_ok = wr & (~full | rd_ok);
  always_comb begin
    wr_ptr_d    = wr_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d    = rd_ok ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    level_d     = (wr_ok & ~rd_ok) ? level_q + (ADDR_W+1)'(1) :
                  (rd_ok & ~wr_ok) ? level_q - (ADDR_W+1)'(1) : level_q;
    // a fresh error on the clearing edge keeps its flag set
    overflow_d  = (wr & ~wr_ok) | (overflow_q & ~clr_err);
    underflow_d = (rd & ~rd_ok) | (underflow_q & ~clr_err);
  end
  always_ff @(posedge clk)
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  always_ff @(posedge clk)
    if (rst && wr_ok) mem_q[wr_ptr_q] <= din;
`ifdef FIFO_FWFT_EN
  assign dout = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_W-1:0] dout_q;
  always_ff @(posedge clk)
    if (!rst) dout_q <= '0;
    else if (rd_ok) dout_q <= mem_q[rd_ptr_q];
  assign dout = dout_q;
`endif
endmodule
